data_mem_bank: RTL and testbench
================================

# data_mem_bank

Parametrised successor to the processor's single-port data memory. Word-organised synchronous RAM with byte-lane write enables, configurable read latency with a `rd_valid` strobe, address range/alignment checking, and an optional post-reset zero-fill sequencer. Sits between the load/store stage and the data-side memory map. The load/store stage must hold off while `ready` is low and consume read data on `rd_valid`.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 256: number of words; must be a power of 2, at least 2.
- `ADDR_W`, 32: byte-address width.
- `RD_LAT`, 1: read latency in cycles; only 1 or 2 are legal.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the whole array after reset; 0 = contents untouched by reset.

Derived values:
- `NB = DATA_W/8`
- `OFS = log2(NB)`
- `IDX_W = log2(DEPTH)`

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `wr_en` in 1: write request, sampled on the edge.
- `rd_en` in 1: read request, sampled on the edge.
- `addr` in ADDR_W: byte address.
- `wr_data` in DATA_W: write word.
- `byte_en` in NB: per-byte write enable; bit i controls `wr_data[8i+7:8i]`.
- `rd_data` out DATA_W: registered read word.
- `rd_valid` out 1: one-cycle strobe marking new `rd_data`.
- `ready` out 1: high when requests are accepted.
- `err` out 1: one-cycle strobe marking a rejected access.

## Operation
- **Word index:** `idx = addr[OFS+IDX_W-1:OFS]`.
- **Misaligned access:** `addr[OFS-1:0] != 0`.
- **Out of range:** any `addr` bit at or above `OFS+IDX_W` is set.
- **Faulting request:** `wr_en` or `rd_en` is high and the address is misaligned or out of range. The memory is not written, no read is issued, no `rd_valid` is produced, and `err` pulses.
- **Legal write:** writes only the bytes enabled by `byte_en`. `byte_en == 0` is a legal no-op and does not raise `err`.
- **Simultaneous `rd_en` and `wr_en`:** both are performed. A read of the same index returns the OLD word (read-first).

FSM states:
- **CLEAR:** `ready = 0`. Entered while `rst_n == 0` (with `clr_cnt = 0`). Each cycle with `rst_n == 1`, writes 0 to `mem[clr_cnt]` and increments `clr_cnt`. After writing `DEPTH-1` it moves to RUN. With `CLEAR_ON_RESET = 0`, CLEAR moves to RUN on the first cycle with `rst_n == 1` and writes nothing.
- **RUN:** `ready = 1`. Services requests. Stays in RUN until reset.

Requests while `ready == 0`:
- Ignored completely: no write, no read, no `err`.
- The requester must not present them; the bench checks that they are dropped.

Reset behaviour:
- Reset at any time, including in the middle of CLEAR or with reads in flight, returns the FSM to CLEAR and sets `clr_cnt = 0`.
- It also flushes the read pipeline: no `rd_valid` is issued for reads accepted before the reset.
- Reset values: `rd_data = 0`, `rd_valid = 0`, `err = 0`, `ready = 0`.
- `rd_data` holds its last value between reads. It is not cleared by the zero-fill.

## Timing
- **Read, `RD_LAT = 1`:** request sampled at edge N; `rd_data` and `rd_valid` are updated at edge N, so both are visible during cycle N..N+1.
- **Read, `RD_LAT = 2`:** one extra output register; `rd_data` and `rd_valid` appear one edge later (edge N+1).
- **Throughput:** back-to-back reads are allowed every cycle, giving one `rd_valid` per accepted read, in order.
- **Write:** the array is updated at the sampling edge. A read sampled at the next edge sees the new data.
- **`err`:** registered; high for exactly the cycle following the faulting request's edge. This is independent of `RD_LAT`.
- **CLEAR duration:** `ready` rises after exactly `DEPTH` cycles with `rst_n` high (after 1 cycle when `CLEAR_ON_RESET = 0`).
- **Index wrap:** `clr_cnt` never wraps; CLEAR exits at `DEPTH-1`.

## Test plan
- **Reset and clear** (DEPTH=256, CLEAR_ON_RESET=1): release reset → `ready` is 0 for 256 cycles and then 1. A subsequent read of `addr = 0x3FC` returns 0 with `rd_valid` one cycle later.
- **Byte-lane write:** write `0xAABBCCDD` with `byte_en = 4'b1111` to `0x10`, then write `0x11223344` with `byte_en = 4'b0101` → reading `0x10` returns `0xAA22CC44`.
- **Same-cycle read/write:** `rd_en` and `wr_en` both high at `0x20`, which holds `0x5`, writing `0x9` → `rd_data = 0x5`. The next read returns `0x9`.
- **Fault checks:**
  - Read at `0x401` → `err` pulses for 1 cycle, no `rd_valid`.
  - Write at `0x400` → `err` pulses and memory is unchanged.
  - `addr = 0x3FC` → accepted.
- **RD_LAT=2 streaming:** read 4 consecutive addresses holding 1, 2, 3, 4 → `rd_valid` is high for 4 consecutive cycles starting 2 cycles after the first request, with data 1, 2, 3, 4 in order.
- **Reset mid-operation:** assert `rst_n = 0` for 1 cycle at `clr_cnt = 100`, and again with 2 reads in flight → `clr_cnt` restarts at 0, the full 256-cycle clear repeats, and no `rd_valid` is issued for the flushed reads.

Source files
------------

// File: rtl/data_mem_bank.sv
// Word-organised data RAM: byte-lane writes, alignment/range faulting, optional post-reset zero-fill.
// Read data and rd_valid arrive RD_LAT edges after the request; requests are dropped while ready is low.
module data_mem_bank #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                ready,
    output logic                err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFS   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << OFS);
    localparam logic [ADDR_W-1:0] HI_MASK    = {ADDR_W{1'b1}} << (OFS + IDX_W);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  p0_data_q, p0_data_d;
    logic               p0_vld_q, p0_vld_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  mem_wdat;
    logic [NB-1:0]      mem_be;
    logic [DATA_W-1:0]  rd_word;
    logic               fault;
    logic               running;
    logic               acc_rd;
    logic               acc_wr;
    logic               clear_we;

    assign idx     = addr[OFS+IDX_W-1:OFS];
    assign rd_word = mem[idx];
    assign ready   = (state_q == ST_RUN);
    assign err     = err_q;

    // Anything presented during reset or zero-fill is dropped without a fault report.
    always_comb begin
        fault    = (|(addr & ALIGN_MASK)) || (|(addr & HI_MASK));
        running  = rst_n && (state_q == ST_RUN);
        acc_rd   = running && rd_en && !fault;
        acc_wr   = running && wr_en && !fault;
        err_d    = running && (rd_en || wr_en) && fault;
        clear_we = rst_n && (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_RUN;
                end else if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        mem_idx  = idx;
        mem_wdat = wr_data;
        mem_be   = acc_wr ? byte_en : '0;
        if (clear_we) begin
            mem_idx  = clr_cnt_q;
            mem_wdat = '0;
            mem_be   = {NB{1'b1}};
        end
    end

    // Read-first: rd_word is sampled at the same edge that commits a write to that word.
    always_comb begin
        p0_vld_d  = acc_rd;
        p0_data_d = acc_rd ? rd_word : p0_data_q;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) begin
                mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            p0_data_q <= '0;
            p0_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            p0_data_q <= p0_data_d;
            p0_vld_q  <= p0_vld_d;
            err_q     <= err_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] p1_data_q, p1_data_d;
        logic              p1_vld_q, p1_vld_d;

        always_comb begin
            p1_vld_d  = p0_vld_q;
            p1_data_d = p0_vld_q ? p0_data_q : p1_data_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                p1_data_q <= '0;
                p1_vld_q  <= 1'b0;
            end else begin
                p1_data_q <= p1_data_d;
                p1_vld_q  <= p1_vld_d;
            end
        end

        assign rd_data  = p1_data_q;
        assign rd_valid = p1_vld_q;
    end else begin : g_lat1
        assign rd_data  = p0_data_q;
        assign rd_valid = p0_vld_q;
    end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench: two banks (RD_LAT 1 and 2) share one request stream and are checked side by side.
module tb_data_mem_bank;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        ready1, ready2;
    logic        err1, err2;

    int n_vec = 0;
    int n_err = 0;

    data_mem_bank #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .byte_en(byte_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .ready(ready1), .err(err1)
    );

    data_mem_bank #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .byte_en(byte_en), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .ready(ready2), .err(err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        wr_data = '0;
        byte_en = '0;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        wr_en = 1'b1; addr = a; wr_data = d; byte_en = be;
        step();
        check_val("wr_no_err", {31'd0, err1}, 32'd0);
        idle();
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [31:0] exp);
        idle();
        rd_en = 1'b1; addr = a;
        step();
        check_val("rd_vld_lat1", {31'd0, rd_valid1}, 32'd1);
        check_val("rd_dat_lat1", rd_data1, exp);
        check_val("rd_vld_lat2_early", {31'd0, rd_valid2}, 32'd0);
        idle();
        step();
        check_val("rd_vld_lat2", {31'd0, rd_valid2}, 32'd1);
        check_val("rd_dat_lat2", rd_data2, exp);
        check_val("rd_vld_lat1_strobe", {31'd0, rd_valid1}, 32'd0);
        check_val("rd_dat_lat1_hold", rd_data1, exp);
    endtask

    // Counts edges until ready (bounded); optionally presents requests mid-clear that must be dropped.
    task automatic wait_ready(input int limit, input bit inject, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (ready1 !== 1'b1 && cycles < limit) begin
            idle();
            if (inject && cycles == 200) begin
                wr_en = 1'b1; rd_en = 1'b1; addr = 32'h0; wr_data = 32'hDEADBEEF; byte_en = 4'hF;
            end else if (inject && cycles == 201) begin
                rd_en = 1'b1; addr = 32'h401;
            end
            step();
            cycles++;
            if (rd_valid1 || rd_valid2 || err1 || err2) seen = 1'b1;
        end
        idle();
    endtask

    initial begin
        int  cyc;
        bit  seen;

        rst_n = 1'b0;
        idle();
        step(); step(); step();
        check_val("rst_ready1", {31'd0, ready1}, 32'd0);
        check_val("rst_ready2", {31'd0, ready2}, 32'd0);
        check_val("rst_rd_valid", {30'd0, rd_valid1, rd_valid2}, 32'd0);
        check_val("rst_rd_data", rd_data1, 32'd0);
        check_val("rst_err", {30'd0, err1, err2}, 32'd0);

        // Zero-fill takes exactly DEPTH cycles; requests during it are ignored.
        rst_n = 1'b1;
        wait_ready(400, 1'b1, cyc, seen);
        check_val("clear_cycles", cyc, 32'd256);
        check_val("clear_drop", {31'd0, seen}, 32'd0);
        check_val("clear_ready2", {31'd0, ready2}, 32'd1);
        do_rd(32'h3FC, 32'h0);
        do_rd(32'h0, 32'h0);

        // Byte lanes, including an all-disabled write.
        do_wr(32'h10, 32'hAABBCCDD, 4'b1111);
        do_wr(32'h10, 32'h11223344, 4'b0101);
        do_rd(32'h10, 32'hAA22CC44);
        do_wr(32'h10, 32'hFFFFFFFF, 4'b0000);
        do_rd(32'h10, 32'hAA22CC44);

        // Same-cycle read/write returns the old word.
        do_wr(32'h20, 32'h5, 4'hF);
        rd_en = 1'b1; wr_en = 1'b1; addr = 32'h20; wr_data = 32'h9; byte_en = 4'hF;
        step();
        check_val("rw_old_lat1", rd_data1, 32'h5);
        idle();
        step();
        check_val("rw_old_lat2", rd_data2, 32'h5);
        do_rd(32'h20, 32'h9);

        // Faults: misaligned read, out-of-range write, misaligned write.
        rd_en = 1'b1; addr = 32'h401;
        step();
        check_val("flt_rd_err", {30'd0, err1, err2}, 32'd3);
        check_val("flt_rd_vld1", {31'd0, rd_valid1}, 32'd0);
        idle();
        step();
        check_val("flt_rd_err_pulse", {30'd0, err1, err2}, 32'd0);
        check_val("flt_rd_vld2", {31'd0, rd_valid2}, 32'd0);
        wr_en = 1'b1; addr = 32'h400; wr_data = 32'h12345678; byte_en = 4'hF;
        step();
        check_val("flt_wr_err", {30'd0, err1, err2}, 32'd3);
        idle();
        step();
        check_val("flt_wr_err_pulse", {31'd0, err1}, 32'd0);
        wr_en = 1'b1; addr = 32'h22; wr_data = 32'h12345678; byte_en = 4'hF;
        step();
        check_val("flt_mis_wr_err", {31'd0, err1}, 32'd1);
        idle();
        do_rd(32'h0, 32'h0);
        do_rd(32'h20, 32'h9);
        do_wr(32'h3FC, 32'h55, 4'hF);
        do_rd(32'h3FC, 32'h55);

        // Back-to-back stream of four reads.
        for (int i = 0; i < 4; i++) do_wr(32'h40 + 32'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 4) begin
                rd_en = 1'b1; addr = 32'h40 + 32'(4 * i);
            end
            step();
            check_val("strm_vld1", {31'd0, rd_valid1}, (i < 4) ? 32'd1 : 32'd0);
            check_val("strm_vld2", {31'd0, rd_valid2}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
            if (i < 4) check_val("strm_dat1", rd_data1, 32'(i + 1));
            if (i >= 1 && i <= 4) check_val("strm_dat2", rd_data2, 32'(i));
        end
        idle();

        // Reset with reads in flight flushes the pipeline.
        rd_en = 1'b1; addr = 32'h40;
        step();
        check_val("fl_vld1_pre", {31'd0, rd_valid1}, 32'd1);
        check_val("fl_dat1_pre", rd_data1, 32'd1);
        rst_n = 1'b0; rd_en = 1'b1; addr = 32'h44;
        step();
        check_val("fl_vld", {30'd0, rd_valid1, rd_valid2}, 32'd0);
        check_val("fl_rd_data", {rd_data1[15:0], rd_data2[15:0]}, 32'd0);
        check_val("fl_ready", {30'd0, ready1, ready2}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Reset again part-way through the zero-fill; the full fill repeats.
        wait_ready(100, 1'b0, cyc, seen);
        check_val("mid_cycles", cyc, 32'd100);
        check_val("mid_ready", {31'd0, ready1}, 32'd0);
        check_val("mid_no_vld", {31'd0, seen}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_ready(400, 1'b0, cyc, seen);
        check_val("reclear_cycles", cyc, 32'd256);
        check_val("reclear_no_vld", {31'd0, seen}, 32'd0);
        do_rd(32'h3FC, 32'h0);
        do_rd(32'h40, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
